hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. It is the producer of the flush and stall controls that the inter-stage pipeline registers consume:
- Flush/stall controls go to IF/ID, ID/EX, EX/MEM and MEM/WB.
- Forwarding selects go to the EX-stage operand muxes.

Beyond the combinational hazard equations, it runs a data-memory wait-state FSM with timeout, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_ctrl_sat_counter32.sv | 19 +
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions for the RV32I core: result-select and
// forwarding-select encodings plus the forwarding priority helper.
package hazard_ctrl_pkg;

    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (regwrite_m && (rd_m == rs))
                sel = FWD_MEM;
            else if (regwrite_w && (rd_w == rs))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter32.sv
// 32-bit saturating event counter with synchronous clear (clear beats increment).
module sat_counter32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 32'd1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch stall-flush, data-memory
// wait-state FSM with timeout, and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [2:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        CntClr,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           freeze;
    logic           timeout;
    logic           lw_stall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MemReqM && !MemReadyM) begin
                    freeze     = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (MemReadyM) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYCLES)) begin
                    timeout    = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Every output is forced low while RST is held, including the combinational ones.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemTimeout = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        if (RST) begin
            ForwardAE  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
            ForwardBE  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
            MemTimeout = timeout;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall && !PCSrcE;
                StallD = lw_stall && !PCSrcE;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end
        end
    end

    sat_counter32 u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (CntClr),
        .inc   (StallF),
        .count (StallCycles)
    );

    sat_counter32 u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (CntClr),
        .inc   (FlushE),
        .count (FlushCycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a short memory timeout.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [2:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, CntClr;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles, FlushCycles;
    logic [7:0]  ctl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    localparam logic [7:0] CTL_NONE   = 8'b0000_0000;
    localparam logic [7:0] CTL_LW     = 8'b1100_0100;
    localparam logic [7:0] CTL_BR     = 8'b0000_1100;
    localparam logic [7:0] CTL_FREEZE = 8'b1111_0010;
    localparam logic [7:0] CTL_TMO    = 8'b0000_0001;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; ResultSrcE = 3'b000; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        CntClr = 1'b0;
    endtask

    task automatic set_load_use();
        Rs1D = 5'd5; RdE = 5'd5; ResultSrcE = 3'b001;
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        idle_inputs();
        RST = 1'b0;
        // Inputs that would assert outputs if reset did not mask them
        set_load_use(); PCSrcE = 1'b1; MemReqM = 1'b1;
        RdM = 5'd7; Rs1E = 5'd7; RegWriteM = 1'b1;
        #1;
        check("reset_ctl", 32'(ctl), 32'(CTL_NONE));
        check("reset_fwdA", 32'(ForwardAE), 32'd0);
        cyc(); cyc();
        check("reset_stallcnt", StallCycles, 32'd0);
        check("reset_flushcnt", FlushCycles, 32'd0);
        idle_inputs();
        RST = 1'b1;
        #1;
        check("idle_ctl", 32'(ctl), 32'(CTL_NONE));

        // Load-use: one stall cycle
        cyc(); set_load_use(); #1;
        check("lw_ctl", 32'(ctl), 32'(CTL_LW));
        cyc(); idle_inputs(); #1;
        check("lw_release_ctl", 32'(ctl), 32'(CTL_NONE));
        check("lw_stallcnt", StallCycles, 32'd1);
        check("lw_flushcnt", FlushCycles, 32'd1);
        Rs2D = 5'd5; RdE = 5'd5; ResultSrcE = 3'b001; #1;
        check("lw_rs2_ctl", 32'(ctl), 32'(CTL_LW));
        RdE = 5'd0; Rs2D = 5'd0; #1;
        check("lw_rd0_ctl", 32'(ctl), 32'(CTL_NONE));
        idle_inputs();

        // Forwarding priority
        RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
        RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        check("fwdA_mem", 32'(ForwardAE), 32'd2);
        check("fwdB_mem", 32'(ForwardBE), 32'd2);
        RegWriteM = 1'b0; #1;
        check("fwdA_wb", 32'(ForwardAE), 32'd1);
        Rs1E = 5'd0; #1;
        check("fwdA_x0", 32'(ForwardAE), 32'd0);
        check("fwdB_wb", 32'(ForwardBE), 32'd1);
        RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd7; #1;
        check("fwdA_mem_miss", 32'(ForwardAE), 32'd1);
        RegWriteW = 1'b0; #1;
        check("fwdA_none", 32'(ForwardAE), 32'd0);
        idle_inputs();

        // Branch wins over load-use
        cyc(); set_load_use(); PCSrcE = 1'b1; #1;
        check("br_lw_ctl", 32'(ctl), 32'(CTL_BR));
        cyc(); idle_inputs(); #1;
        check("br_stallcnt", StallCycles, 32'd1);
        check("br_flushcnt", FlushCycles, 32'd2);

        // Memory wait: ready on 4th cycle -> 3 freeze cycles
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) begin set_load_use(); PCSrcE = 1'b1; end
            else begin idle_inputs(); MemReqM = 1'b1; end
            #1;
            check($sformatf("wait_freeze%0d", i), 32'(ctl), 32'(CTL_FREEZE));
            cyc();
        end
        idle_inputs(); MemReqM = 1'b1; MemReadyM = 1'b1; #1;
        check("wait_release", 32'(ctl), 32'(CTL_NONE));
        cyc(); idle_inputs(); #1;
        check("wait_stallcnt", StallCycles, 32'd4);
        check("wait_flushcnt", FlushCycles, 32'd2);

        // Timeout: 4 freeze cycles then a one-cycle pulse
        MemReqM = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("tmo_freeze%0d", i), 32'(ctl), 32'(CTL_FREEZE));
            cyc();
        end
        #1;
        check("tmo_pulse", 32'(ctl), 32'(CTL_TMO));
        cyc(); MemReqM = 1'b0; #1;
        check("tmo_back_run", 32'(ctl), 32'(CTL_NONE));
        check("tmo_stallcnt", StallCycles, 32'd8);

        // Reset in the middle of a wait
        MemReqM = 1'b1; #1;
        check("rstwait_freeze1", 32'(ctl), 32'(CTL_FREEZE));
        cyc(); #1;
        check("rstwait_freeze2", 32'(ctl), 32'(CTL_FREEZE));
        cyc(); RST = 1'b0; #1;
        check("rstwait_ctl", 32'(ctl), 32'(CTL_NONE));
        cyc();
        check("rstwait_stallcnt", StallCycles, 32'd0);
        MemReqM = 1'b0; RST = 1'b1; #1;
        check("rstwait_nopulse", 32'(ctl), 32'(CTL_NONE));
        cyc(); #1;
        check("rstwait_run", 32'(ctl), 32'(CTL_NONE));

        // Saturation and clear
        force dut.u_stall_cnt.count = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.count;
        set_load_use();
        cyc(); check("sat_1", StallCycles, 32'hFFFF_FFFE);
        cyc(); check("sat_2", StallCycles, 32'hFFFF_FFFF);
        cyc(); check("sat_hold", StallCycles, 32'hFFFF_FFFF);
        check("sat_flushcnt", FlushCycles, 32'd3);
        CntClr = 1'b1;
        cyc();
        check("clr_stallcnt", StallCycles, 32'd0);
        check("clr_flushcnt", FlushCycles, 32'd0);
        idle_inputs();
        cyc();
        check("clr_hold", StallCycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
